// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit feeder and its FIFO.
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_BUSY_TMO = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered count/full/empty. The head entry is visible
// on dout without a read cycle, so a pop can load it in the same edge.
module fifo_sync #(
  parameter int DATA_W = uart_pkg::DATA_W,
  parameter int DEPTH  = uart_pkg::DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              wr_en;
  logic              rd_en;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign rd_en = pop && !empty_q;
  assign wr_en = push && (!full_q || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + ADDR_W'(rd_en);
    count_d  = count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
    full_d   = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered UART transmit front end: queues bytes from system logic and launches
// them one at a time to the transceiver, pacing on tx_busy.
module uart_tx_feeder #(
  parameter int DATA_W   = uart_pkg::DATA_W,
  parameter int DEPTH    = uart_pkg::DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BUSY_TMO = uart_pkg::DEF_BUSY_TMO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tmo_err,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy
);
  import uart_pkg::*;

  localparam int TMO_W = $clog2(BUSY_TMO) + 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              overflow_q, overflow_d;
  logic              tmo_err_q, tmo_err_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0] fifo_dout;
  logic              pop;

  fifo_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A new byte leaves only when nothing is outstanding and the line is free.
  assign pop = (state_q == IDLE) && !empty && !tx_busy;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    tmo_err_d  = 1'b0;
    tmo_cnt_d  = tmo_cnt_q;
    overflow_d = push && full && !pop;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d  = fifo_dout;
          tx_start_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = tx_busy ? WAIT_DONE : WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q == TMO_W'(BUSY_TMO - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
      tmo_err_q  <= tmo_err_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  assign tmo_err  = tmo_err_q;

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Producer-side front end for the UART transmit path: buffers bytes written by system logic and issues them one at a time to the transceiver's tx_start/tx_data interface, pacing on tx_busy.
- Sits between a byte source (command/response logic, or the receive path in echo builds) and the uart transceiver. It replaces the direct rx_done->tx_start tie with a buffered, back-pressure-aware writer.
- Bytes that arrive while a frame is on the wire are queued, not lost.

Parameters:
- DATA_W, 8, byte width.
- DEPTH, 16, FIFO entries; must be a power of 2.
- ADDR_W, 4, log2(DEPTH).
- BUSY_TMO, 8, cycles to wait for tx_busy to rise after tx_start before the byte is treated as sent.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- push  in  1  write strobe; one byte is written per cycle while high.
- push_data  in  DATA_W  byte to queue; sampled when push=1.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- count  out  ADDR_W+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse when a push is dropped.
- tmo_err  out  1  one-cycle pulse when BUSY_TMO expires.
- tx_start  out  1  one-cycle launch pulse to the uart transceiver.
- tx_data  out  DATA_W  byte being launched; held stable from tx_start until the frame completes.
- tx_busy  in  1  transmitter busy, driven by the uart transceiver.

Behaviour:
- Reset (reset=0 at an edge):
  - FIFO pointers and count go to 0; empty=1, full=0.
  - tx_start=0, tx_data=0, overflow=0, tmo_err=0, state=IDLE.
  - A frame already on the wire is not aborted; the feeder simply waits for it to finish (see IDLE).
- All outputs are registered.
- FIFO:
  - Write when push=1 and (!full or a pop occurs in the same cycle).
  - push=1 with full=1 and no pop: the byte is dropped, overflow=1 for one cycle, count is unchanged.
  - Pop only in IDLE, and only when !empty.
  - Simultaneous push and pop: count is unchanged and both complete.
  - Pointers wrap modulo DEPTH; full and empty are derived from count.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: when !empty && !tx_busy, pop the head into the tx_data register, set tx_start=1 and go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_start=0.
    - If tx_busy=1, go to WAIT_DONE.
    - Otherwise go to WAIT_BUSY and clear the timeout counter.
  - WAIT_BUSY:
    - tx_busy=1: go to WAIT_DONE.
    - Counter reaches BUSY_TMO-1: pulse tmo_err and go to IDLE.
  - WAIT_DONE: when tx_busy=0, go to IDLE. The next byte may launch on the following edge.
- Latency: push at edge k into an empty, idle feeder gives empty=0 after k, and tx_start=1 in the cycle after edge k+1. That is 2 cycles from push to launch.
- tx_start is never high for two consecutive cycles. At most one byte is outstanding.
- tx_data changes only at a pop, so it stays stable through LAUNCH, WAIT_BUSY and WAIT_DONE.
- count is pure binary with width ADDR_W+1, so count=DEPTH is representable.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - the DATA_W constant;
  - the default DEPTH and BUSY_TMO values.
- One sub-module, fifo_sync. It is a single-clock FIFO with ports push, pop, din, dout, full, empty and count, and a synchronous active-low reset. The feeder contains only the FSM, the tx_data register and the timeout counter.

Test Plan:
- Single byte: push 0x55 into an idle feeder. Expect tx_start for exactly one cycle, 2 cycles later, with tx_data=0x55. Model busy high for 100 cycles; expect no second tx_start and empty=1.
- Burst: push 0x01..0x05 back-to-back while a busy model holds each frame for 50 cycles. Expect five tx_start pulses in order 0x01..0x05, each launched only after tx_busy falls; count peaks at 4.
- Overflow: hold tx_busy=1 and push 17 bytes 0x10..0x20. Expect full=1 and count=16. Expect overflow to pulse once, on the 17th push (0x20 dropped). Release busy; expect 0x10..0x1F transmitted.
- Simultaneous push and pop at full: at the IDLE pop cycle with count=16, push 0xAA. Expect count to stay 16 and 0xAA to be transmitted last.
- Timeout: keep tx_busy=0 and push 0x3C. Expect tx_start, then tmo_err 8 cycles after LAUNCH, then return to IDLE. A next push 0x3D launches normally.
- Reset mid-frame: assert reset=0 for 1 cycle during WAIT_DONE with 3 bytes queued while tx_busy stays 1. Expect count=0, tx_data=0, and no tx_start until tx_busy falls and a new push occurs.
